lfsr_index_finder: RTL
======================

LFSR_INDEX_FINDER -- requirements
Module: lfsr_index_finder

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 wb_clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a search; sampled only in IDLE.
REQ-005 sw_in  input  8  tap-select mask, latched on accepted start.
REQ-006 target  input  8  LFSR value to locate, latched on accepted start.
REQ-007 seq_idx  output  8  step index k at which the LFSR equals target; 0 when not found.
REQ-008 found  output  1  high when the last search matched; held until the next accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse marking search completion.

Function
REQ-011 SHALL be the inverse of the team's pseudo-random generator: given a mask and a value, it SHALL return the sequence index that produces that value.
REQ-012 SHALL set tap0 to the index of the lowest set bit of the latched mask (default 1 if none) and tap1 to the second-lowest set bit (default 0 if fewer than two bits are set).
REQ-013 SHALL start from seed value(0) = 8'h01 and compute the step as value(k+1) = {value(k)[6:0], value(k)[tap0] ^ value(k)[tap1]}.
REQ-014 SHALL have states IDLE, LOAD, SEARCH and DONE, and SHALL go to IDLE from any illegal encoding.
REQ-015 In IDLE with start=1, SHALL latch sw_in and target and go to LOAD; start SHALL be ignored in all other states.
REQ-016 In LOAD, SHALL compute the taps, set cur=8'h01 and k=0, and go to SEARCH.
REQ-017 In SEARCH, when cur==target, SHALL set found=1 and seq_idx=k, then go to DONE.
REQ-018 In SEARCH, when there is no match and k==255, SHALL set found=0 and seq_idx=0, then go to DONE.
REQ-019 In SEARCH, otherwise SHALL set cur=step(cur) and k=k+1 (8-bit; wrap is unreachable because of REQ-018).
REQ-020 In DONE, SHALL assert done for one cycle, drop busy, and go to IDLE.
REQ-021 Latency: done SHALL be high exactly k+3 rising edges after the edge that sampled start; for no match this is 258 edges.
REQ-022 SHALL keep counting if the LFSR locks at 8'h00; this is not an error.
REQ-023 The first match SHALL win, giving the smallest k.
REQ-024 seq_idx and found SHALL hold their values in IDLE until the next accepted start; they SHALL NOT be cleared by start alone.

Reset
REQ-025 On wb_rst_i=1 at a clock edge, SHALL set state=IDLE and clear busy, done, found, seq_idx, cur and k; this holds from any state, including mid-SEARCH.
REQ-026 A start asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold the state encoding, LFSR_SEED=8'h01, TAP0_DEFAULT=1, TAP1_DEFAULT=0 and MAX_IDX=255, so they can be reused by the generator.
REQ-028 The step function SHALL be one combinational sub-module, lfsr8_step (inputs cur, tap0 and tap1; output next), shared with the generator.
REQ-029 The tap priority encoder and the FSM SHALL stay inside lfsr_index_finder.

Verification
REQ-030 mask 8'h03, target 8'h01 -> found=1, seq_idx=0, done 3 edges after start.
REQ-031 mask 8'h03, target 8'h0D (sequence 01,03,06,0D) -> found=1, seq_idx=3, done 6 edges after start.
REQ-032 mask 8'h00 (default taps), target 8'h06 -> found=1, seq_idx=2.
REQ-033 mask 8'h01 (fb=0; sequence 01,02,...,80,00), target 8'h80 -> seq_idx=7; target 8'h03 -> found=0, seq_idx=0, done 258 edges after start.
REQ-034 start pulsed again during SEARCH -> ignored, result unchanged; wb_rst_i asserted mid-SEARCH -> next cycle IDLE with all outputs 0, and a fresh search afterwards gives the correct result.

Source files
------------

// File: rtl/lfsr_index_finder_pkg.sv
// lfsr_index_finder_pkg: state encoding and LFSR constants shared by the finder and the generator.
package lfsr_index_finder_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SEARCH = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [7:0] LFSR_SEED    = 8'h01;
  localparam logic [2:0] TAP0_DEFAULT = 3'd1;
  localparam logic [2:0] TAP1_DEFAULT = 3'd0;
  localparam logic [7:0] MAX_IDX      = 8'd255;
endpackage

// File: rtl/lfsr8_step.sv
// lfsr8_step: one shift of the 8-bit LFSR with a two-tap xor feedback into bit 0.
module lfsr8_step (
  input  logic [7:0] cur,
  input  logic [2:0] tap0,
  input  logic [2:0] tap1,
  output logic [7:0] next
);
  assign next = {cur[6:0], cur[tap0] ^ cur[tap1]};
endmodule

// File: rtl/lfsr_index_finder.sv
// lfsr_index_finder: walks the LFSR from the seed until it hits target, reporting the step index.
module lfsr_index_finder
  import lfsr_index_finder_pkg::*;
(
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start,
  input  logic [7:0] sw_in,
  input  logic [7:0] target,
  output logic [7:0] seq_idx,
  output logic       found,
  output logic       busy,
  output logic       done
);
  logic [2:0] state_q;
  logic [7:0] mask_q, target_q, cur_q, k_q, seq_idx_q, step_d;
  logic [2:0] tap0_q, tap1_q, tap0_d, tap1_d;
  logic       found_q, busy_q, done_q;
  logic [1:0] n;
  always_comb begin
    tap0_d = TAP0_DEFAULT;
    tap1_d = TAP1_DEFAULT;
    n      = 2'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask_q[i]) begin
        tap0_d = (n == 2'd0) ? i[2:0] : tap0_d;
        tap1_d = (n == 2'd1) ? i[2:0] : tap1_d;
        n      = (n == 2'd2) ? n : n + 2'd1;
      end
    end
  end
  lfsr8_step u_step (
    .cur  (cur_q),
    .tap0 (tap0_q),
    .tap1 (tap1_q),
    .next (step_d)
  );
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      target_q  <= '0;
      tap0_q    <= TAP0_DEFAULT;
      tap1_q    <= TAP1_DEFAULT;
      cur_q     <= '0;
      k_q       <= '0;
      seq_idx_q <= '0;
      found_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          mask_q   <= sw_in;
          target_q <= target;
          busy_q   <= 1'b1;
          state_q  <= S_LOAD;
        end
        S_LOAD: begin
          tap0_q  <= tap0_d;
          tap1_q  <= tap1_d;
          cur_q   <= LFSR_SEED;
          k_q     <= '0;
          state_q <= S_SEARCH;
        end
        S_SEARCH: if (cur_q == target_q) begin
          found_q   <= 1'b1;
          seq_idx_q <= k_q;
          state_q   <= S_DONE;
        end else if (k_q == MAX_IDX) begin
          found_q   <= 1'b0;
          seq_idx_q <= '0;
          state_q   <= S_DONE;
        end else begin
          cur_q <= step_d;
          k_q   <= k_q + 8'd1;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
  assign seq_idx = seq_idx_q;
  assign found   = found_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule
